// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : register index, pipeline-slot types and hazard helpers    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pipe_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_idx_t dest;
    logic     is_load;
  } slot_t;

  localparam slot_t BUBBLE_SLOT = '{dest: REG_ZERO, is_load: 1'b0};

  // A source matches a producer only if it is actually read and is not r0.
  function automatic logic srcHit(input reg_idx_t src, input logic notRead,
                                  input reg_idx_t dest);
    return !notRead && (src != REG_ZERO) && (src == dest);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_tracker : counts down mult/div busy cycles after an issue     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module muldiv_tracker #(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy
);

  // MULDIV_LAT is limited to 1..15 so a 4-bit counter always holds it.
  localparam logic [3:0] c_LOAD = 4'(MULDIV_LAT);

  logic [3:0] r_count;
  logic [3:0] w_countNext;
  logic       r_busy;

  always_comb begin
    w_countNext = r_count;
    if (start) begin
      w_countNext = c_LOAD;
    end else if (r_count != 4'd0) begin
      w_countNext = r_count - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_count <= w_countNext;
      r_busy  <= (w_countNext != 4'd0);
    end
  end

  assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_scoreboard : load-use and mult/div interlock for decode       |
// | Mult/div tracking is built only when HAZARD_MULDIV_EN is defined.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       IssueValid,
  input  logic [4:0] Rs,
  input  logic [4:0] Rt,
  input  logic       xRs,
  input  logic       xRt,
  input  logic [4:0] Rd,
  input  logic       RdWrite,
  input  logic       IsLoad,
  input  logic       IsMulDiv,
  input  logic       MfHiLo,
  input  logic       Flush,
  output logic       Stall,
  output logic [4:0] PortA,
  output logic [4:0] PortB,
  output logic       MulDivBusy
);

  slot_t r_exSlot;
  slot_t r_memSlot;
  logic  w_loadUse;
  logic  w_mdStall;
  logic  w_issue;

  // Only the EX slot can stall; a MEM-slot load is covered by forwarding.
  assign w_loadUse = IssueValid && r_exSlot.is_load &&
                     (srcHit(Rs, xRs, r_exSlot.dest) || srcHit(Rt, xRt, r_exSlot.dest));

`ifdef HAZARD_MULDIV_EN
  logic w_mdStart;

  assign w_mdStart = IssueValid && IsMulDiv && !Stall && !Flush;
  assign w_mdStall = IssueValid && (IsMulDiv || MfHiLo) && MulDivBusy;

  muldiv_tracker #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldivTracker (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_mdStart),
    .busy    (MulDivBusy)
  );
`else
  logic w_unusedMd;
  localparam int c_unusedLat = MULDIV_LAT;

  assign w_unusedMd = IsMulDiv ^ MfHiLo;
  assign w_mdStall  = 1'b0;
  assign MulDivBusy = 1'b0;
`endif

  assign Stall   = w_loadUse || w_mdStall;
  assign w_issue = IssueValid && RdWrite && !Stall && !Flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exSlot  <= BUBBLE_SLOT;
      r_memSlot <= BUBBLE_SLOT;
    end else begin
      r_memSlot <= r_exSlot;
      r_exSlot  <= w_issue ? '{dest: Rd, is_load: IsLoad} : BUBBLE_SLOT;
    end
  end

  assign PortA = r_exSlot.dest;
  assign PortB = r_memSlot.dest;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_scoreboard : directed stimulus with a queued scoreboard    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_hazard_scoreboard;

`ifdef HAZARD_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       IssueValid = 1'b0;
  logic [4:0] Rs = '0;
  logic [4:0] Rt = '0;
  logic       xRs = 1'b1;
  logic       xRt = 1'b1;
  logic [4:0] Rd = '0;
  logic       RdWrite = 1'b0;
  logic       IsLoad = 1'b0;
  logic       IsMulDiv = 1'b0;
  logic       MfHiLo = 1'b0;
  logic       Flush = 1'b0;
  logic       Stall;
  logic [4:0] PortA;
  logic [4:0] PortB;
  logic       MulDivBusy;

  typedef struct {
    int         cyc;
    logic       stall;
    logic [4:0] a;
    logic [4:0] b;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  hazard_scoreboard #(.MULDIV_LAT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .IssueValid (IssueValid),
    .Rs         (Rs),
    .Rt         (Rt),
    .xRs        (xRs),
    .xRt        (xRt),
    .Rd         (Rd),
    .RdWrite    (RdWrite),
    .IsLoad     (IsLoad),
    .IsMulDiv   (IsMulDiv),
    .MfHiLo     (MfHiLo),
    .Flush      (Flush),
    .Stall      (Stall),
    .PortA      (PortA),
    .PortB      (PortB),
    .MulDivBusy (MulDivBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int c, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected within that cycle.
  task automatic step(input bit rstn, input bit iv,
                      input logic [4:0] rs, input bit xrs,
                      input logic [4:0] rt, input bit xrt,
                      input logic [4:0] rd, input bit rdw, input bit ld,
                      input bit md, input bit mf, input bit fl,
                      input bit eS, input logic [4:0] eA, input logic [4:0] eB,
                      input bit eBusy);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rstn; IssueValid = iv;
    Rs = rs; xRs = xrs; Rt = rt; xRt = xrt;
    Rd = rd; RdWrite = rdw; IsLoad = ld;
    IsMulDiv = md; MfHiLo = mf; Flush = fl;
    cyc++;
    e.cyc = cyc; e.stall = eS; e.a = eA; e.b = eB; e.busy = eBusy;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("stall", e.cyc, int'(Stall), int'(e.stall));
        check("portA", e.cyc, int'(PortA), int'(e.a));
        check("portB", e.cyc, int'(PortB), int'(e.b));
        check("busy",  e.cyc, int'(MulDivBusy), int'(e.busy));
      end
    end
  end

  initial begin : driver
    //    rst iv rs xrs rt xrt rd rdw ld md mf fl | S  A   B   busy
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0);   // in reset
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0);
    // load-use on Rs
    step(1, 1, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0,  0, 0,  0,  0);
    step(1, 1, 5, 0, 0, 1, 6, 1, 0, 0, 0, 0,  1, 5,  0,  0);
    step(1, 1, 5, 0, 0, 1, 6, 1, 0, 0, 0, 0,  0, 0,  5,  0);
    // ALU-use: no stall
    step(1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0,  0, 6,  0,  0);
    step(1, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 7,  6,  0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  7,  0);
    // r0 and unread sources never stall; MEM match never stalls
    step(1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0,  0, 0,  0,  0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0);
    step(1, 1, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0,  0, 0,  0,  0);
    step(1, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 3,  0,  0);
    step(1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  3,  0);
    // load-use on Rt
    step(1, 1, 0, 1, 0, 1, 12, 1, 1, 0, 0, 0, 0, 0,  0,  0);
    step(1, 1, 0, 1, 12, 0, 12, 1, 0, 0, 0, 0, 1, 12, 0,  0);
    step(1, 1, 0, 1, 12, 0, 12, 1, 0, 0, 0, 0, 0, 0,  12, 0);
    // flushed load never enters EX
    step(1, 1, 0, 1, 0, 1, 9, 1, 1, 0, 0, 1,  0, 12, 0,  0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  12, 0);
    // flush during a load-use stall: single bubble
    step(1, 1, 0, 1, 0, 1, 4, 1, 1, 0, 0, 0,  0, 0,  0,  0);
    step(1, 1, 4, 0, 0, 1, 8, 1, 0, 0, 0, 1,  1, 4,  0,  0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  4,  0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0);
    // mult/div then MfHiLo each cycle
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0,  0,  0);
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, MD, 0, 0, MD);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0,  0,  0);
    // flushed mult/div does not start the counter
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1,  0, 0,  0,  0);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0,  0,  0);
    // back-to-back mult/div stalls
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0,  0,  0);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0,  MD, 0, 0, MD);
    // fill the slots, then reset mid-count
    step(1, 1, 0, 1, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0,  0,  MD);
    step(1, 1, 0, 1, 0, 1, 11, 1, 0, 0, 0, 0, 0, 10, 0,  MD);
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0,  0,  0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    check("drain", cyc, q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
